aes_inv_rounds: RTL and testbench
=================================

Name: aes_inv_rounds

Overview:
Iterative AES-128 inverse cipher (FIPS-197 §5.3). It is the decrypt-direction counterpart of the existing encrypt round sequencer.
- Accepts cyphertext and the original cipher key on a load pulse.
- Forward-expands the key to round key 10, then runs the inverse rounds at one round per clock, deriving round keys backwards on the fly.
- Presents plaintext with a sticky done flag.

Parameters:
None. AES-128 only; NR = 10 is a package constant.

Ports:
int_osc  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
load  input  1  start request, sampled on the rising edge
key  input  128  cipher key (round key 0), byte 0 at [127:120]
cyphertext  input  128  block to decrypt, byte 0 at [127:120]
busy  output  1  high from accepted load until done rises
done  output  1  high once plaintext is valid; stays high until the next accepted load or reset
plaintext  output  128  decrypted block; valid while done is high

Behaviour:
- Byte/state mapping: byte i sits at [127-8i -: 8] and maps to state row i%4, column i/4 (FIPS-197 column-major).
- Reset values: busy=0, done=0, plaintext=0, internal state/rk/ct registers=0, cnt=0, FSM=IDLE.
- FSM states and transitions: IDLE -> EXPAND -> ADDKEY -> ROUND -> FINAL -> IDLE.
- Load acceptance: load is accepted only in IDLE. An accepted load at edge N:
  - ct_reg <= cyphertext, rk <= key, cnt <= 1;
  - done <= 0, busy <= 1, FSM <= EXPAND.
- load while busy: ignored; no effect on the operation in flight.
- load in IDLE with done=1: accepted; done falls at the same edge.
- EXPAND (edges N+1..N+10):
  - rk <= fwd_step(rk, rcon[cnt]), then cnt++.
  - After edge N+10, rk = round key 10 and FSM moves to ADDKEY.
- fwd_step(w0..w3, rc):
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rc,24'h0};
  - w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- ADDKEY (edge N+11): state <= ct_reg ^ rk; cnt <= 10; FSM <= ROUND.
- ROUND (edges N+12..N+20, nine rounds):
  - rk_prev = inv_step(rk, rcon[cnt]);
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_prev);
  - rk <= rk_prev; cnt--.
  - FSM moves to FINAL when cnt reaches 1.
- inv_step(w0..w3, rc):
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0;
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rc,24'h0}.
- FINAL (edge N+21):
  - rk0 = inv_step(rk, rcon[1]); this must equal key.
  - plaintext <= InvSubBytes(InvShiftRows(state)) ^ rk0.
  - done <= 1, busy <= 0, FSM <= IDLE.
- Latency: done is first observed high 21 cycles after the accepted load edge, constant for every input.
- InvShiftRows: row r is rotated right by r bytes.
- InvMixColumns: matrix {0e,0b,0d,09} over GF(2^8), reduction polynomial 0x11B.
- Datapath is purely combinational between registers: 16 inverse S-boxes for state, 4 forward S-boxes for the key step. No multi-cycle paths.
- Reset asserted mid-operation: everything returns to reset values asynchronously. After deassertion the block waits in IDLE for a fresh load; no partial result is ever exposed.
- plaintext holds its value after done until the next FINAL; it is not cleared on load.

Decomposition:
- Package aes_pkg: NR=10; rcon[1:10] = 01,02,04,08,10,20,40,80,1B,36; SBOX and INV_SBOX 256x8 constant arrays; fsm_state_t enum {IDLE, EXPAND, ADDKEY, ROUND, FINAL}; functions gmul2, gmul(x,k), sub_word, rot_word, inv_shift_rows, inv_mix_columns.
- One sub-module: aes_key_step. It is combinational, with a dir input selecting fwd/inv, and ports rk_in, rcon, rk_out. It is reusable by the encrypt side.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, done rising exactly 21 cycles after load, busy high for cycles 1..20.
- FIPS-197 App B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734; internal rk after EXPAND = d014f9a8c9ee2589e13f0cc8b6630ca6.
- SP800-38A ECB: same key, ct 3ad77bb40d7a3660a89ecaf32466ef97 -> plaintext 6bc1bee22e409f96e93d7e117393172a. Run this back-to-back after the previous vector with load pulsed while done=1 -> done drops that edge, second result correct.
- load re-pulsed at cycle 5 and cycle 15 of an operation -> ignored, result and 21-cycle latency unchanged.
- reset asserted at cycle 12 of an operation -> busy/done/plaintext go to 0 immediately without a clock edge. A subsequent load of vector C.1 completes correctly in 21 cycles.
- Idle with load=0 for 50 cycles after done -> done stays 1, plaintext stable, busy 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8)/byte-matrix helpers.
// State bytes are column-major: byte i lives at [127-8i -: 8], row i%4, column i/4.
package aes_pkg;

  localparam int NR = 10;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_INV = 1'b1;

  typedef enum logic [2:0] {IDLE, EXPAND, ADDKEY, ROUND, FINAL} fsm_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Counter values outside 1..10 occur in IDLE/ADDKEY; they select no round constant.
  function automatic logic [7:0] get_rcon(input logic [3:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    for (int i = 1; i <= NR; i++) begin
      if (idx == 4'(i)) rc = RCON[i];
    end
    return rc;
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = gmul2(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, combinational; dir selects forward (rk_i -> rk_i+1)
// or inverse (rk_i -> rk_i-1). Both directions share the same four forward S-boxes.
module aes_key_step
  import aes_pkg::*;
(
  input  logic         dir,
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_in, x0, x1, x2, x3;

  assign w0 = rk_in[127:96];
  assign w1 = rk_in[95:64];
  assign w2 = rk_in[63:32];
  assign w3 = rk_in[31:0];

  // Inverse direction recovers the previous w3 before it feeds the S-boxes.
  assign sub_in = (dir == DIR_INV) ? (w3 ^ w2) : w3;
  assign x0     = w0 ^ sub_word(rot_word(sub_in)) ^ {rcon, 24'h0};

  assign x1 = (dir == DIR_INV) ? (w1 ^ w0) : (w1 ^ x0);
  assign x2 = (dir == DIR_INV) ? (w2 ^ w1) : (w2 ^ x1);
  assign x3 = (dir == DIR_INV) ? (w3 ^ w2) : (w3 ^ x2);

  assign rk_out = {x0, x1, x2, x3};

endmodule

// File: rtl/aes_inv_rounds.sv
// Iterative AES-128 decryptor: 10-cycle forward key expansion, then one inverse round
// per clock with round keys derived backwards; done rises 21 cycles after an accepted load.
module aes_inv_rounds
  import aes_pkg::*;
(
  input  logic         int_osc,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] key,
  input  logic [127:0] cyphertext,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext
);

  fsm_state_t   fsm_q, fsm_d;
  logic [127:0] st_q;
  logic [127:0] rk;
  logic [127:0] ct_reg;
  logic [3:0]   cnt;

  logic         key_dir;
  logic [7:0]   rcon_cur;
  logic [127:0] rk_next;

  assign rcon_cur = get_rcon(cnt);
  assign busy     = (fsm_q != IDLE);

  aes_key_step u_key_step (
    .dir    (key_dir),
    .rk_in  (rk),
    .rcon   (rcon_cur),
    .rk_out (rk_next)
  );

  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d   = fsm_q;
    key_dir = DIR_INV;
    case (fsm_q)
      IDLE:   if (load) fsm_d = EXPAND;
      EXPAND: begin
        key_dir = DIR_FWD;
        if (cnt == 4'(NR)) fsm_d = ADDKEY;
      end
      ADDKEY: fsm_d = ROUND;
      ROUND:  if (cnt == 4'd2) fsm_d = FINAL;
      FINAL:  fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      st_q      <= '0;
      rk        <= '0;
      ct_reg    <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      plaintext <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (load) begin
            ct_reg <= cyphertext;
            rk     <= key;
            cnt    <= 4'd1;
            done   <= 1'b0;
          end
        end
        EXPAND: begin
          rk  <= rk_next;
          cnt <= cnt + 4'd1;
        end
        ADDKEY: begin
          st_q <= ct_reg ^ rk;
          cnt  <= 4'(NR);
        end
        ROUND: begin
          st_q <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_next);
          rk   <= rk_next;
          cnt  <= cnt - 4'd1;
        end
        FINAL: begin
          // rk_next here is round key 0, i.e. the original cipher key.
          plaintext <= inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_next;
          rk        <= rk_next;
          cnt       <= '0;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_rounds.sv
// Known-answer bench for aes_inv_rounds: vector table through a scoreboard queue,
// plus load-while-busy, mid-operation reset and long-idle sequences.
module tb_aes_inv_rounds;

  logic         int_osc = 1'b0;
  logic         reset;
  logic         load;
  logic [127:0] key;
  logic [127:0] cyphertext;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q [$];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 int_osc = ~int_osc;

  aes_inv_rounds dut (
    .int_osc    (int_osc),
    .reset      (reset),
    .load       (load),
    .key        (key),
    .cyphertext (cyphertext),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a one-cycle load; returns at the negedge just after the load edge.
  task automatic start(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                       input bit push);
    @(negedge int_osc);
    key        = k;
    cyphertext = c;
    load       = 1'b1;
    if (push) exp_q.push_back(p);
    @(negedge int_osc);
    load = 1'b0;
    check("load_clears_done", {127'b0, done}, 128'd1 - 128'd1);
    check("load_sets_busy", {127'b0, busy}, 128'd1);
  endtask

  // Waits for done (bounded), optionally re-pulsing load at cycles p1/p2, then scores.
  task automatic finish_op(input string name, input int p1, input int p2,
                           input bit chk_rk, input logic [127:0] rk10);
    int lat = 0;
    bit busy_ok = 1'b1;
    logic [127:0] exp;
    while (!done && lat < 100) begin
      load = (lat == p1 || lat == p2);
      if (load) begin
        key        = ~key;
        cyphertext = ~cyphertext;
      end
      @(negedge int_osc);
      lat++;
      if (!done && (busy !== 1'b1)) busy_ok = 1'b0;
      if (chk_rk && lat == 10) check({name, "_rk10"}, dut.rk, rk10);
    end
    load = 1'b0;
    check({name, "_busy_window"}, {127'b0, busy_ok}, 128'd1);
    check({name, "_latency"}, 128'(lat), 128'd21);
    check({name, "_busy_low"}, {127'b0, busy}, 128'd0);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_plaintext"}, plaintext, exp);
    end
  endtask

  initial begin
    logic [127:0] saved;
    bit idle_ok;

    vecs[0] = '{C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};

    reset      = 1'b1;
    load       = 1'b0;
    key        = '0;
    cyphertext = '0;
    #12;
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_done", {127'b0, done}, 128'd0);
    check("rst_plaintext", plaintext, 128'd0);
    @(negedge int_osc);
    reset = 1'b0;

    // Back-to-back: each later load lands while done is still high.
    for (int i = 0; i < 3; i++) begin
      start(vecs[i].key, vecs[i].ct, vecs[i].pt, 1'b1);
      finish_op($sformatf("vec%0d", i), -1, -1, (i == 1), B_RK10);
      check($sformatf("vec%0d_done", i), {127'b0, done}, 128'd1);
    end

    start(C1_KEY, C1_CT, C1_PT, 1'b1);
    finish_op("repulse", 5, 15, 1'b0, '0);

    // Reset mid-flight: outputs clear without a clock edge.
    start(C1_KEY, C1_CT, C1_PT, 1'b0);
    repeat (11) @(negedge int_osc);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", {127'b0, busy}, 128'd0);
    check("midrst_done", {127'b0, done}, 128'd0);
    check("midrst_plaintext", plaintext, 128'd0);
    @(negedge int_osc);
    reset = 1'b0;
    repeat (3) @(negedge int_osc);
    check("post_rst_idle_done", {127'b0, done}, 128'd0);
    check("post_rst_idle_busy", {127'b0, busy}, 128'd0);
    start(C1_KEY, C1_CT, C1_PT, 1'b1);
    finish_op("after_rst", -1, -1, 1'b0, '0);

    saved   = plaintext;
    idle_ok = 1'b1;
    repeat (50) begin
      @(negedge int_osc);
      if (done !== 1'b1 || busy !== 1'b0 || plaintext !== saved) idle_ok = 1'b0;
    end
    check("idle_hold", {127'b0, idle_ok}, 128'd1);
    check("idle_plaintext", plaintext, C1_PT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
